cla_add_scheduler: RTL

Nibble-serial multi-word adder scheduler that shares a single 4-bit `CLA_Adder` instance between two requesters. It arbitrates between requesters round-robin and captures the winner's WIDTH-bit operands. It then feeds the adder one nibble per cycle, least-significant first, registering the carry between nibbles. It returns the WIDTH-bit sum, carry-out and requester ID through a valid/ready response port. It sits between the arithmetic datapath clients and the shared CLA.

---
 rtl/cla_add_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cla_add_scheduler.sv
// Nibble-serial multi-word adder that time-shares one 4-bit carry-lookahead
// adder between two round-robin requesters. The optional signed-overflow
// output is enabled by defining CLA_ADD_SCHED_OVF_EN.

// 4-bit carry-lookahead adder slice shared by the scheduler.
module CLA_Adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are formed directly from generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_add_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
`ifdef CLA_ADD_SCHED_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             c_q, id_q, last_id_q;
  logic [IW-1:0]    idx_q;
  logic             any_valid, grant_id, accept, last_nib;
  logic [3:0]       cla_a, cla_b, cla_sum;
  logic             cla_cout;

  // Alternate on contention; a lone requester always wins.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_id_q : req1_valid;
  assign accept    = (state_q == IDLE) & any_valid;
  assign last_nib  = (idx_q == IW'(NIB - 1));

  // Next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: if (any_valid) begin
        req0_ready = ~grant_id;
        req1_ready = grant_id;
        state_d    = RUN;
      end
      RUN:  if (last_nib) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Select the operand nibbles addressed by the pass index.
  always_comb begin
    cla_a = 4'h0;
    cla_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        cla_a = a_q[4*i +: 4];
        cla_b = b_q[4*i +: 4];
      end
    end
  end

  CLA_Adder u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (c_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Merge this pass's nibble into the accumulated sum.
  always_comb begin
    sum_d = sum_q;
    if (state_q == RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx_q == IW'(i)) sum_d[4*i +: 4] = cla_sum;
      end
    end
  end

  // Operand capture and the per-nibble carry chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      c_q       <= 1'b0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      idx_q     <= '0;
    end else if (accept) begin
      a_q       <= grant_id ? req1_a : req0_a;
      b_q       <= grant_id ? req1_b : req0_b;
      c_q       <= grant_id ? req1_cin : req0_cin;
      id_q      <= grant_id;
      last_id_q <= grant_id;
      idx_q     <= '0;
    end else if (state_q == RUN) begin
      sum_q <= sum_d;
      c_q   <= cla_cout;
      idx_q <= last_nib ? '0 : idx_q + 1'b1;
    end
  end

`ifdef CLA_ADD_SCHED_OVF_EN
  logic ovf_q;

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if ((state_q == RUN) && last_nib)
      ovf_q <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (cla_sum[3] ^ a_q[WIDTH-1]);
  end

  assign rsp_ovf = ovf_q;
`endif

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = c_q;
  assign rsp_id    = id_q;
endmodule
